// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with HI/LO result registers
// One shift-add or restoring-division step per cycle; HI/LO only change on completion or MTHI/MTLO.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [63:0] work;
    logic [31:0] opnd;
    logic [31:0] a_raw;
    logic        neg_lo;
    logic        neg_hi;
    logic        div_zero;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[31];
    assign b_neg     = signed_op & b[31];
    assign a_mag     = a_neg ? (~a + 32'd1) : a;
    assign b_mag     = b_neg ? (~b + 32'd1) : b;

    // MUL: work = {partial product, remaining multiplier bits}
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, work[31:1]};

    // DIV: work = {partial remainder, dividend bits shifting into quotient}
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    assign div_shift = {work[63:32], work[31]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_next  = div_diff[32] ? {div_shift[31:0], work[30:0], 1'b0}
                                    : {div_diff[31:0],  work[30:0], 1'b1};

    logic        last;
    logic [63:0] prod_s;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign last   = (cnt == 5'd31);
    assign prod_s = neg_lo ? (~mul_next + 64'd1) : mul_next;
    assign quo    = div_next[31:0];
    assign rem    = div_next[63:32];
    assign quo_s  = neg_lo ? (~quo + 32'd1) : quo;
    assign rem_s  = neg_hi ? (~rem + 32'd1) : rem;

    always_comb begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        if (state == DIV) begin
            // Divide by zero reports the untouched dividend and an all-ones quotient
            res_hi = div_zero ? a_raw : rem_s;
            res_lo = div_zero ? 32'hFFFF_FFFF : quo_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = op[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 5'd0;
            work     <= 64'd0;
            opnd     <= 32'd0;
            a_raw    <= 32'd0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= 5'd0;
                        work     <= {32'd0, a_mag};
                        opnd     <= b_mag;
                        a_raw    <= a;
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        div_zero <= (b == 32'd0);
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                MUL, DIV: begin
                    work <= (state == MUL) ? mul_next : div_next;
                    cnt  <= cnt + 5'd1;
                    if (last) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                DONE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'd0;
        case (o)
            2'b00: p = 64'(sx * sy);
            2'b01: p = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Follows an operation from its start edge to the done cycle; returns at the done-cycle negedge.
    task automatic wait_done(input bit poke, output logic [63:0] got, output int lat,
                             output int busy_cyc, output bit overlap, output bit held);
        logic [63:0] prev;
        got = 64'd0; lat = 0; busy_cyc = 0; overlap = 1'b0; held = 1'b1; prev = 64'd0;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                prev = {hi, lo};
            end
            if (busy && done) overlap = 1'b1;
            if (busy) busy_cyc++;
            if (busy && ({hi, lo} !== prev)) held = 1'b0;
            if (poke && k == 5) begin
                start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_DEAD;
            end
            if (poke && k == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            if (done) begin
                lat = k;
                got = {hi, lo};
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b1;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk); hi_we = 1'b0;
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL mthi_lo: got %h expected 0", lo); end
        lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        @(negedge clk); lo_we = 1'b0;
        n_checks++; if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL mtlo: got %h expected 123456789abcdef0", {hi, lo}); end
    endtask

    task automatic test_multu_max();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        sb_q.push_back(64'hFFFF_FFFE_0000_0001);
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL multu_max_result: got %h expected %h", got, exp); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL multu_max_latency: got %0d expected 33", lat); end
        n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL multu_max_busy_cycles: got %0d expected 32", bc); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL multu_max_busy_done_overlap: got %b expected 0", ov); end
        @(negedge clk);
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL multu_max_after_done: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_mult_neg();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL mult_neg_result: got %h expected %h", got, exp); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL mult_neg_hilo_held: got %b expected 1", held); end
    endtask

    task automatic test_div();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL div_neg_result: got %h expected %h", got, exp); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_neg_latency: got %0d expected 33", lat); end
        sb_q.push_back({32'd2, 32'd14});
        launch(2'b11, 32'd100, 32'd7);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL divu_result: got %h expected %h", got, exp); end
    endtask

    task automatic test_div_corner();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        sb_q.push_back({32'h0000_0064, 32'hFFFF_FFFF});
        launch(2'b11, 32'h0000_0064, 32'd0);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL divu_zero_result: got %h expected %h", got, exp); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_zero_latency: got %0d expected 33", lat); end
        sb_q.push_back({32'hFFFF_FFF9, 32'hFFFF_FFFF});
        launch(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL div_zero_result: got %h expected %h", got, exp); end
        sb_q.push_back({32'h0000_0000, 32'h8000_0000});
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL div_overflow_result: got %h expected %h", got, exp); end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        sb_q.push_back({32'd0, 32'd42});
        launch(2'b01, 32'd6, 32'd7);
        wait_done(1'b1, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL busy_ignore_result: got %h expected %h", got, exp); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL busy_ignore_held: got %b expected 1", held); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d expected 33", lat); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_no_restart: got %b expected 0", busy); end
    endtask

    task automatic test_start_lo_we();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        sb_q.push_back({32'd2, 32'd14});
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        launch(2'b11, 32'd100, 32'd7);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL start_lo_we_result: got %h expected %h", got, exp); end
    endtask

    task automatic test_done_write();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
        launch(2'b00, 32'd3, 32'hFFFF_FFFB);
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL done_write_result: got %h expected %h", got, exp); end
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        @(negedge clk);
        lo_we = 1'b0; start = 1'b0;
        n_checks++; if ({hi, lo} !== {exp[63:32], 32'hCAFE_F00D}) begin n_fail++; $display("FAIL done_write_override: got %h expected %h", {hi, lo}, {exp[63:32], 32'hCAFE_F00D}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        logic [1:0]  ro; logic [31:0] ra; logic [31:0] rb;
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300)));
            sb_q.push_back(model(ro, ra, rb));
            launch(ro, ra, rb);
            wait_done(1'b0, got, lat, bc, ov, held);
            exp = sb_q.pop_front();
            n_checks++; if (got !== exp || lat !== 33) begin n_fail++; $display("FAIL random_op%0d op=%0d a=%h b=%h: got %h lat %0d expected %h lat 33", i, ro, ra, rb, got, lat, exp); end
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] got; logic [63:0] exp; int lat; int bc; bit ov; bit held;
        bit saw_done;
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        @(posedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL abort_busy_done: got %b expected 00", {busy, done}); end
        n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
        sb_q.push_back({32'd0, 32'd15});
        reset = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        wait_done(1'b0, got, lat, bc, ov, held);
        exp = sb_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL after_reset_result: got %h expected %h", got, exp); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL after_reset_latency: got %0d expected 33", lat); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        test_reset();
        test_mthi_mtlo();
        test_multu_max();
        test_mult_neg();
        test_div();
        test_div_corner();
        test_busy_ignore();
        test_start_lo_we();
        test_done_write();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
